// File: rtl/tff_counter.sv
// Multi-mode WIDTH-bit counter: per-bit toggle, count up/down and parallel load, with an
// optional modulus, a wrap/saturate policy, a registered terminal-count pulse and a sticky overflow.
module tff_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_VAL  = 0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t_mask,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] LIMIT = (MOD_VAL == 0) ? {WIDTH{1'b1}} : WIDTH'(MOD_VAL - 1);

    localparam logic [1:0] ModeToggle = 2'b00;
    localparam logic [1:0] ModeUp     = 2'b01;
    localparam logic [1:0] ModeDown   = 2'b10;
    localparam logic [1:0] ModeLoad   = 2'b11;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_or_above, above;

    // Written without a direct "> LIMIT" so the compare stays non-constant when LIMIT is all-ones.
    assign at_or_above = !(cnt_q < LIMIT);
    assign above       = at_or_above && (cnt_q != LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (en) begin
            unique case (mode)
                ModeToggle: cnt_d = cnt_q ^ t_mask;
                ModeUp: begin
                    if (at_or_above) begin
                        cnt_d = SATURATE ? LIMIT : '0;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                ModeDown: begin
                    if (cnt_q == '0) begin
                        cnt_d = SATURATE ? '0 : LIMIT;
                        tc_d  = 1'b1;
                    end else if (above) begin
                        // Out-of-range value from a load: snap back into range silently.
                        cnt_d = LIMIT;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                ModeLoad: cnt_d = d;
            endcase
        end
        // A new terminal-count event beats a coincident clear.
        ovf_d = tc_d | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench for tff_counter: four instances (wrap, modulo-10 wrap, modulo-10 saturate,
// 1-bit legacy) share one stimulus stream and are compared against an integer reference model.
module tb_tff_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] t_mask = 4'h0;
    logic [3:0] d = 4'h0;
    logic       clr_ovf = 1'b0;

    logic [3:0] q0, q1, q2;
    logic       q3;
    logic       tc0, tc1, tc2, tc3;
    logic       ovf0, ovf1, ovf2, ovf3;

    int checks = 0;
    int errors = 0;

    // Expected {q[3:0], tc, ovf} per instance, pushed at the edge, popped by the monitor.
    logic [5:0] exp_q[4][$];

    int lim[4]  = '{15, 9, 9, 1};
    int sat[4]  = '{0, 0, 1, 0};
    int mask[4] = '{15, 15, 15, 1};
    int mq[4];
    int movf[4];

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MOD_VAL(0), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t_mask(t_mask), .d(d),
        .clr_ovf(clr_ovf), .q(q0), .tc(tc0), .ovf(ovf0)
    );
    tff_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b0)) u_mod (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t_mask(t_mask), .d(d),
        .clr_ovf(clr_ovf), .q(q1), .tc(tc1), .ovf(ovf1)
    );
    tff_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t_mask(t_mask), .d(d),
        .clr_ovf(clr_ovf), .q(q2), .tc(tc2), .ovf(ovf2)
    );
    tff_counter #(.WIDTH(1), .MOD_VAL(0), .SATURATE(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t_mask(t_mask[0:0]), .d(d[0:0]),
        .clr_ovf(clr_ovf), .q(q3), .tc(tc3), .ovf(ovf3)
    );

    function automatic logic [5:0] got(input int k);
        case (k)
            0:       return {q0, tc0, ovf0};
            1:       return {q1, tc1, ovf1};
            2:       return {q2, tc2, ovf2};
            default: return {3'b000, q3, tc3, ovf3};
        endcase
    endfunction

    // Monitor: outputs are registered, so every instance presents a result each cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (exp_q[k].size() > 0) begin
                logic [5:0] e, g;
                e = exp_q[k].pop_front();
                g = got(k);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL inst%0d t=%0t: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                             k, $time, g[5:2], g[1], g[0], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, g, e);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] tm, input logic [3:0] dd, input logic co);
        rst = r; en = e; mode = m; t_mask = tm; d = dd; clr_ovf = co;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            int t;
            t = 0;
            if (!r) begin
                mq[k] = 0;
                movf[k] = 0;
            end else begin
                if (e) begin
                    case (m)
                        2'b00: mq[k] = mq[k] ^ (int'(tm) & mask[k]);
                        2'b01: begin
                            if (mq[k] >= lim[k]) begin
                                mq[k] = sat[k] ? lim[k] : 0;
                                t = 1;
                            end else mq[k] = mq[k] + 1;
                        end
                        2'b10: begin
                            if (mq[k] == 0) begin
                                mq[k] = sat[k] ? 0 : lim[k];
                                t = 1;
                            end else if (mq[k] > lim[k]) mq[k] = lim[k];
                            else mq[k] = mq[k] - 1;
                        end
                        default: mq[k] = int'(dd) & mask[k];
                    endcase
                end
                movf[k] = (t != 0 || (movf[k] != 0 && !co)) ? 1 : 0;
            end
            exp_q[k].push_back({mq[k][3:0], t[0], movf[k][0]});
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset with arbitrary inputs, then idle.
        step(1'b0, 1'b1, 2'b01, 4'hF, 4'h7, 1'b0);
        step(1'b0, 1'b1, 2'b11, 4'h3, 4'h9, 1'b1);
        chk("reset q", int'(q0), 0);
        chk("reset tc", int'(tc0), 0);
        chk("reset ovf", int'(ovf0), 0);
        step(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 1'b0);
        chk("idle q", int'(q0), 0);

        // Wrap up across the full range.
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
            if (i == 16) begin
                chk("wrap q", int'(q0), 0);
                chk("wrap tc", int'(tc0), 1);
            end
        end
        chk("after wrap q", int'(q0), 1);
        chk("after wrap tc", int'(tc0), 0);
        chk("sticky ovf", int'(ovf0), 1);
        step(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 1'b1);
        chk("clr ovf", int'(ovf0), 0);

        // Modulo-10 down through zero.
        step(1'b1, 1'b1, 2'b11, 4'h0, 4'd2, 1'b0);
        step(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
        chk("mod down 1", int'(q1), 1);
        step(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
        chk("mod down 0", int'(q1), 0);
        step(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
        chk("mod down 9", int'(q1), 9);
        chk("mod down tc", int'(tc1), 1);
        step(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
        chk("mod down 8", int'(q1), 8);

        // Saturate at LIMIT and at 0.
        step(1'b1, 1'b1, 2'b11, 4'h0, 4'd8, 1'b0);
        step(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        chk("sat up1 q", int'(q2), 9);
        chk("sat up1 tc", int'(tc2), 0);
        step(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        chk("sat up2 tc", int'(tc2), 1);
        step(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        chk("sat up3 q", int'(q2), 9);
        chk("sat up3 tc", int'(tc2), 1);
        step(1'b1, 1'b1, 2'b11, 4'h0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
        chk("sat down q", int'(q2), 0);
        chk("sat down tc", int'(tc2), 1);

        // Toggle, 4-bit mask and legacy 1-bit.
        step(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'b00, 4'b1010, 4'h0, 1'b0);
        chk("toggle 1010", int'(q0), 10);
        step(1'b1, 1'b1, 2'b00, 4'b1010, 4'h0, 1'b0);
        chk("toggle 0000", int'(q0), 0);
        step(1'b1, 1'b1, 2'b00, 4'b0001, 4'h0, 1'b0);
        chk("legacy 1", int'(q3), 1);
        step(1'b1, 1'b1, 2'b00, 4'b0001, 4'h0, 1'b0);
        chk("legacy 0", int'(q3), 0);

        // Corners: clear coinciding with a wrap; out-of-range load then UP; reset mid-count.
        step(1'b1, 1'b1, 2'b11, 4'h0, 4'd15, 1'b0);
        step(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b1);
        chk("clr vs wrap ovf", int'(ovf0), 1);
        step(1'b1, 1'b1, 2'b11, 4'h0, 4'd12, 1'b0);
        chk("oor load q", int'(q1), 12);
        step(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        chk("oor up q", int'(q1), 0);
        chk("oor up tc", int'(tc1), 1);
        chk("oor sat q", int'(q2), 9);
        step(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        chk("mid reset q", int'(q1), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) != 0), ($urandom_range(7) != 0), 2'($urandom_range(3)),
                 4'($urandom), 4'($urandom), ($urandom_range(7) == 0));
        end

        @(negedge clk);
        for (int k = 0; k < 4; k++) chk("scoreboard drained", exp_q[k].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
